// File: rtl/vga_capture.sv
// vga_capture: locks onto VGA sync timing and emits a down-sampled
// pixel stream as single-entry valid/ready write requests.
module vga_capture #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int V_TOTAL     = 521,
    parameter int V_ACT_START = 31,
    parameter int SCALE_SHIFT = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_hSync,
    input  logic        i_vSync,
    input  logic [11:0] i_color,
    input  logic        i_wrReady,
    input  logic        i_clrStatus,
    output logic        o_wrValid,
    output logic [31:0] o_pxlAddr,
    output logic [31:0] o_pxlData,
    output logic        o_locked,
    output logic        o_frameDone,
    output logic        o_syncErr,
    output logic        o_overrun
);

    localparam logic [9:0]  CNT_MAX = 10'd1023;
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_START = 10'(H_ACT_START);
    localparam logic [9:0]  V_START = 10'(V_ACT_START);
    localparam logic [10:0] H_LO    = 11'(H_ACT_START);
    localparam logic [10:0] H_HI    = 11'(H_ACT_START + 640);
    localparam logic [10:0] V_LO    = 11'(V_ACT_START);
    localparam logic [10:0] V_HI    = 11'(V_ACT_START + 480);
    localparam logic [9:0]  V_PRE   = 10'(V_ACT_START + 479);
    localparam logic [9:0]  ALIGN   = 10'((1 << SCALE_SHIFT) - 1);

    typedef enum logic {
        SEARCH,
        LOCKED
    } stateT;

    stateT state;
    stateT stateNext;

    logic       hSyncQ;
    logic       hSyncPrev;
    logic       vSyncQ;
    logic       vSyncPrev;
    logic       hFall;
    logic       vFall;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic [9:0] hOff;
    logic [9:0] vOff;
    logic       hActive;
    logic       vActive;
    logic       samplePt;
    logic       xfer;
    logic       drop;
    logic       syncErrNext;

    assign hFall = hSyncPrev & ~hSyncQ;
    assign vFall = vSyncPrev & ~vSyncQ;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            hSyncQ    <= 1'b1;
            hSyncPrev <= 1'b1;
            vSyncQ    <= 1'b1;
            vSyncPrev <= 1'b1;
            hCount    <= '0;
            vCount    <= '0;
        end else begin
            hSyncQ    <= i_hSync;
            hSyncPrev <= hSyncQ;
            vSyncQ    <= i_vSync;
            vSyncPrev <= vSyncQ;
            if (hFall) begin
                hCount <= '0;
            end else if (hCount != CNT_MAX) begin
                hCount <= hCount + 10'd1;
            end
            // a frame start outranks the line increment
            if (vFall) begin
                vCount <= '0;
            end else if (hFall && vCount != CNT_MAX) begin
                vCount <= vCount + 10'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= SEARCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        syncErrNext = 1'b0;
        unique case (state)
            SEARCH: begin
                if (vFall) begin
                    stateNext = LOCKED;
                end
            end
            LOCKED: begin
                if ((hFall && hCount != H_LAST) ||
                    (hCount == CNT_MAX) ||
                    (vFall && vCount != V_LAST)) begin
                    stateNext   = SEARCH;
                    syncErrNext = 1'b1;
                end
            end
            default: stateNext = SEARCH;
        endcase
    end

    assign o_locked = (state == LOCKED);

    assign hOff    = hCount - H_START;
    assign vOff    = vCount - V_START;
    assign hActive = ({1'b0, hCount} >= H_LO) && ({1'b0, hCount} < H_HI);
    assign vActive = ({1'b0, vCount} >= V_LO) && ({1'b0, vCount} < V_HI);

    assign samplePt = (state == LOCKED) && hActive && vActive &&
                      ((hOff & ALIGN) == '0) && ((vOff & ALIGN) == '0);

    assign xfer = o_wrValid & i_wrReady;
    assign drop = samplePt & o_wrValid & ~i_wrReady;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_wrValid   <= 1'b0;
            o_pxlAddr   <= '0;
            o_pxlData   <= '0;
            o_frameDone <= 1'b0;
            o_syncErr   <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            // single holding slot: a new sample may replace it only as it leaves
            if (samplePt && !drop) begin
                o_wrValid <= 1'b1;
                o_pxlAddr <= {16'h0, 8'(vOff >> SCALE_SHIFT),
                              8'(hOff >> SCALE_SHIFT)};
                o_pxlData <= {20'h0, i_color};
            end else if (xfer) begin
                o_wrValid <= 1'b0;
            end
            o_overrun   <= drop | (o_overrun & ~i_clrStatus);
            o_syncErr   <= syncErrNext;
            o_frameDone <= (state == LOCKED) && hFall && !vFall &&
                           (vCount == V_PRE);
        end
    end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_TOTAL, 800, pixel clocks per line.
REQ-002 Parameter H_ACT_START, 144, first active hCount.
REQ-003 Parameter V_TOTAL, 521, lines per frame.
REQ-004 Parameter V_ACT_START, 31, first active vCount.
REQ-005 Parameter SCALE_SHIFT, 2, log2 of down-sample factor per axis (640x480 -> 160x120).
REQ-006 i_clk  in  1  pixel clock; all logic on rising edge.
REQ-007 i_reset_n  in  1  synchronous reset, active-low.
REQ-008 i_hSync  in  1  horizontal sync, active-low.
REQ-009 i_vSync  in  1  vertical sync, active-low.
REQ-010 i_color  in  12  RGB444 pixel, {R,G,B}.
REQ-011 i_wrReady  in  1  downstream accepts write.
REQ-012 i_clrStatus  in  1  clears sticky status.
REQ-013 o_wrValid  out  1  write request valid.
REQ-014 o_pxlAddr  out  32  {16'h0, pxlY[7:0], pxlX[7:0]}.
REQ-015 o_pxlData  out  32  {20'h0, color[11:0]}.
REQ-016 o_locked  out  1  timing lock achieved.
REQ-017 o_frameDone  out  1  one-cycle pulse at end of active frame.
REQ-018 o_syncErr  out  1  one-cycle pulse on timing violation.
REQ-019 o_overrun  out  1  sticky: sample dropped.

Function
REQ-020 Syncs SHALL be registered once; falling edge = previous 1, current 0 (registered values).
REQ-021 hCount (10-bit) SHALL load 0 on the cycle the hSync falling edge is detected, else increment, saturating at 1023.
REQ-022 vCount (10-bit) SHALL load 0 on vSync falling edge, else increment on each hSync falling edge, saturating at 1023.
REQ-023 States SHALL be SEARCH and LOCKED; o_locked = (state == LOCKED).
REQ-024 SEARCH -> LOCKED on vSync falling edge.
REQ-025 LOCKED -> SEARCH with o_syncErr pulse when: hSync falling edge with hCount != H_TOTAL-1; hCount reaches 1023; or vSync falling edge with vCount != V_TOTAL-1.
REQ-026 A simultaneous vSync and hSync falling edge SHALL load vCount 0, not increment it.
REQ-027 Active region: H_ACT_START <= hCount < H_ACT_START+640 and V_ACT_START <= vCount < V_ACT_START+480.
REQ-028 Sample point: LOCKED, active, and low SCALE_SHIFT bits of (hCount-H_ACT_START) and (vCount-V_ACT_START) both zero.
REQ-029 pxlX = (hCount-H_ACT_START)>>SCALE_SHIFT, pxlY = (vCount-V_ACT_START)>>SCALE_SHIFT, each truncated to 8 bits.
REQ-030 At a sample point, i_color at that cycle SHALL appear on o_pxlData, with o_wrValid=1, the next cycle (latency 1).
REQ-031 Transfer SHALL occur on o_wrValid & i_wrReady; o_wrValid, o_pxlAddr and o_pxlData SHALL hold stable until transfer.
REQ-032 If a sample point occurs while o_wrValid=1 and i_wrReady=0, the new sample SHALL be dropped and o_overrun set.
REQ-033 A sample point coinciding with a transfer SHALL load the new sample; this is not an overrun.
REQ-034 o_overrun SHALL clear on i_clrStatus; if a set occurs in the same cycle, set wins.
REQ-035 o_frameDone SHALL pulse on the hSync falling edge that makes vCount = V_ACT_START+480 while LOCKED.
REQ-036 Leaving LOCKED SHALL drop a pending o_wrValid only after its transfer; no new samples are taken in SEARCH.

Reset
REQ-037 In a cycle with i_reset_n=0: state=SEARCH, hCount=vCount=0, sync registers=1, o_wrValid=0, o_pxlAddr=0, o_pxlData=0, o_locked=0, o_frameDone=0, o_syncErr=0, o_overrun=0.
REQ-038 Reset asserted mid-frame or mid-handshake SHALL abandon the pending write without transfer.

Verification
REQ-039 Drive standard 800x521 timing, i_wrReady=1, color = hCount[11:0] -> o_locked rises after the first vSync edge; the first write of each frame has addr 0x0000 and data H_ACT_START; 19200 writes per frame; one o_frameDone per frame.
REQ-040 Sample at pixel (x=644, y=31+8) -> addr 0x0002_00A0? No: pxlX=(644-144)>>2=125, pxlY=2 -> addr 0x0000_027D.
REQ-041 Shorten one line to 799 clocks -> o_syncErr pulses once, o_locked=0; writes stop; relock at the next vSync edge.
REQ-042 Hold i_wrReady=0 for 5 clocks after a write -> the data stays stable, the next sample is dropped, o_overrun=1 until i_clrStatus.
REQ-043 Assert i_reset_n=0 for one cycle with o_wrValid=1 -> all outputs 0 on the next cycle, state SEARCH.
REQ-044 Simultaneous vSync/hSync falling edge after 520 lines -> no o_syncErr, vCount=0, lock retained.
